// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - UART receiver with byte FIFO behind a simple request/response register port
module uart_rx_mmio #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          push_req;
    logic          push_en;
    logic          pop_en;
    logic          fifo_empty;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign unused_bits = ^{req_wdata, req_addr[31:4]};

    assign req_ready  = !resp_valid;
    assign accept     = req_valid && req_ready;
    assign fifo_empty = (count == '0);

    // A stop bit sampled high completes a good frame; full FIFO drops it
    assign push_req = (state == S_STOP) && (timer == BIT_LAST) && rx_sync;
    assign push_en  = push_req && (count != FULL_CNT);
    assign pop_en   = accept && !req_wen && (req_addr[3:0] == 4'h8) && !fifo_empty;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM: mid-bit sampling driven by the bit timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer     <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read data decoded from FIFO state at the acceptance cycle
    always_comb begin
        rd_data = '0;
        if (!req_wen) begin
            case (req_addr[3:0])
                4'h0:    rd_data = {31'b0, !fifo_empty};
                4'h8:    rd_data = fifo_empty ? 32'd0 : {24'b0, mem[rd_ptr]};
                default: rd_data = '0;
            endcase
        end
    end

    // Single-cycle response registered one clock after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= accept;
            resp_rdata <= accept ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - self-checking bench for uart_rx_mmio
module tb_uart_rx_mmio;

    localparam int CPB = 16;

    logic        clk;
    logic        reset_n;
    logic        uart_rx;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    uart_rx_mmio #(
        .CLK_HZ    (1600),
        .BAUD      (100),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rx   (uart_rx),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                check("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [31:0] exp);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        exp_q.push_back(exp);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        tick(1);
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_wdata = '0;
        check("resp_valid_t1", {31'b0, resp_valid}, 32'd1);
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        tick(1);
        check("resp_valid_t2", {31'b0, resp_valid}, 32'd0);
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
        tick(20);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        uart_rx   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;

        vecs[0] = '{32'h0, 1'b0, 32'h0,        32'h0};
        vecs[1] = '{32'h8, 1'b0, 32'h0,        32'h0};
        vecs[2] = '{32'h8, 1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{32'h0, 1'b0, 32'h0,        32'h0};
        vecs[4] = '{32'h4, 1'b0, 32'h0,        32'h0};
        vecs[5] = '{32'hC, 1'b0, 32'h0,        32'h0};
        vecs[6] = '{32'h0, 1'b1, 32'h12345678, 32'h0};
        vecs[7] = '{32'h8, 1'b0, 32'h0,        32'h0};

        tick(3);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        reset_n = 1'b1;
        tick(5);

        // Empty FIFO: reads, writes and unmapped offsets
        for (int i = 0; i < 8; i++) begin
            bus(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].exp);
        end

        // Basic byte
        send_byte(8'hA5, 1'b1);
        bus(32'h0, 1'b0, 32'h0, 32'h1);
        bus(32'h8, 1'b1, 32'hFFFFFFFF, 32'h0);
        bus(32'h0, 1'b0, 32'h0, 32'h1);
        bus(32'h8, 1'b0, 32'h0, 32'hA5);
        bus(32'h0, 1'b0, 32'h0, 32'h0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        bus(32'h0, 1'b0, 32'h0, 32'h0);

        // Framing error then a good byte
        send_byte(8'h3C, 1'b0);
        bus(32'h0, 1'b0, 32'h0, 32'h0);
        send_byte(8'h11, 1'b1);
        bus(32'h8, 1'b0, 32'h0, 32'h11);
        bus(32'h0, 1'b0, 32'h0, 32'h0);

        // Overflow: 17 bytes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            bus(32'h8, 1'b0, 32'h0, 32'(i));
        end
        bus(32'h8, 1'b0, 32'h0, 32'h0);
        bus(32'h0, 1'b0, 32'h0, 32'h0);

        // Reset during bit 4 aborts the frame
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            tick(CPB);
        end
        uart_rx = 1'b1;
        tick(8);
        reset_n = 1'b0;
        tick(4);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        reset_n = 1'b1;
        tick(200);
        bus(32'h0, 1'b0, 32'h0, 32'h0);
        send_byte(8'h7E, 1'b1);
        bus(32'h0, 1'b0, 32'h0, 32'h1);
        bus(32'h8, 1'b0, 32'h0, 32'h7E);
        bus(32'h0, 1'b0, 32'h0, 32'h0);

        tick(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
